// File: rtl/paging_mapper.sv
// paging_mapper: responder for SMS-style mapper register writes plus the
// combinational CPU address translator for ROM, cartridge RAM and system RAM.
// Optional feature macro: CART_RAM_EN. When it is defined, ctrl[3] maps slot 2
// (0x8000-0xBFFF) to cartridge RAM, and ctrl[2] selects the cartridge RAM page.
module paging_mapper #(
  parameter int ROM_BANK_BITS = 5,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      paging_RQ,
  input  logic                      MREQ,
  input  logic                      Rd_Wr,
  input  logic [15:0]               addr,
  input  logic [7:0]                data_in,
  output logic                      flush0,
  output logic                      busy,
  output logic                      rom_sel,
  output logic [ROM_BANK_BITS+13:0] rom_addr,
  output logic                      cart_ram_sel,
  output logic [14:0]               cart_ram_addr,
  output logic                      sys_ram_sel,
  output logic [12:0]               sys_ram_addr
);

  // The counter is always at least one bit wide, so SETTLE_CYCLES = 0 still elaborates.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_SETTLE,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cnt_next;
  logic                     w_capture;
  logic                     w_write_en;

  // The request is captured while IDLE, so later changes on the bus cannot affect the write.
  logic [1:0]               r_hold_addr;
  logic [7:0]               r_hold_data;
  logic                     r_hold_hit;
  logic                     w_hit;

  // Bank registers are only ROM_BANK_BITS wide, so bank numbers wrap on the write.
  logic [7:0]               r_ctrl;
  logic [ROM_BANK_BITS-1:0] r_bank0;
  logic [ROM_BANK_BITS-1:0] r_bank1;
  logic [ROM_BANK_BITS-1:0] r_bank2;
  logic [ROM_BANK_BITS-1:0] w_bank_data;

  logic [1:0]               w_slot;
  logic                     w_low_fixed;
  logic                     w_cart;
  logic [ROM_BANK_BITS-1:0] w_bank;
  logic                     w_unused;

  assign w_hit       = (addr[15:2] == 14'h3FFF) && MREQ && !Rd_Wr;
  assign w_bank_data = ROM_BANK_BITS'(r_hold_data);

  // FSM state and settle counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic, settle countdown and the handshake outputs
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    w_write_en   = 1'b0;
    flush0       = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (paging_RQ) begin
          w_capture    = 1'b1;
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        // If the request was not a mapper-register write, only the handshake completes.
        w_write_en = r_hold_hit;
        if (SETTLE_CYCLES > 0) begin
          w_state_next = S_SETTLE;
          w_cnt_next   = CNT_W'(SETTLE_CYCLES);
        end else begin
          w_state_next = S_DONE;
        end
      end
      S_SETTLE: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_cnt_next   = '0;
          w_state_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        flush0       = 1'b1;
        w_state_next = S_RELEASE;
      end
      S_RELEASE: begin
        // Wait here until the requester drops its request, so one request is serviced only once.
        if (!paging_RQ) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Capture the request target and data when a request is accepted
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hold_addr <= '0;
      r_hold_data <= '0;
      r_hold_hit  <= 1'b0;
    end else if (w_capture) begin
      r_hold_addr <= addr[1:0];
      r_hold_data <= data_in;
      r_hold_hit  <= w_hit;
    end
  end

  // Mapper register file; registers are updated only in the WRITE state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ctrl  <= 8'h00;
      r_bank0 <= ROM_BANK_BITS'(0);
      r_bank1 <= ROM_BANK_BITS'(1);
      r_bank2 <= ROM_BANK_BITS'(2);
    end else if (w_write_en) begin
      case (r_hold_addr)
        2'd0:    r_ctrl  <= r_hold_data;
        2'd1:    r_bank0 <= w_bank_data;
        2'd2:    r_bank1 <= w_bank_data;
        default: r_bank2 <= w_bank_data;
      endcase
    end
  end

  assign w_slot      = addr[15:14];
  assign w_low_fixed = (addr[15:10] == 6'd0);

`ifdef CART_RAM_EN
  assign w_cart        = (w_slot == 2'b10) && r_ctrl[3];
  assign cart_ram_addr = {r_ctrl[2], addr[13:0]};
`else
  assign w_cart        = 1'b0;
  assign cart_ram_addr = '0;
`endif

  // Without cartridge RAM, ctrl is stored but nothing reads it.
  assign w_unused = ^r_ctrl;

  // Decode the address into a single active select and the matching ROM bank
  always_comb begin
    rom_sel      = 1'b0;
    sys_ram_sel  = 1'b0;
    cart_ram_sel = 1'b0;
    w_bank       = '0;
    case (w_slot)
      2'b00: begin
        // The first 1KB always comes from bank 0, so interrupt vectors remain available.
        rom_sel = 1'b1;
        w_bank  = w_low_fixed ? '0 : r_bank0;
      end
      2'b01: begin
        rom_sel = 1'b1;
        w_bank  = r_bank1;
      end
      2'b10: begin
        cart_ram_sel = w_cart;
        rom_sel      = !w_cart;
        w_bank       = r_bank2;
      end
      default: begin
        // Mapper-register writes also land here; system RAM still receives them.
        sys_ram_sel = 1'b1;
      end
    endcase
  end

  assign rom_addr     = {w_bank, addr[13:0]};
  assign sys_ram_addr = addr[12:0];

endmodule

// File: tb/tb_paging_mapper.sv
// Directed bench for paging_mapper: reset state, mapper writes with handshake
// timing, address translation, bank wrap, spurious request, held request and
// reset during SETTLE. Define CART_RAM_EN to check the cartridge RAM build.
module tb_paging_mapper;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        paging_RQ = 1'b0;
  logic        MREQ = 1'b0;
  logic        Rd_Wr = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  data_in = 8'h00;
  logic        flush0;
  logic        busy;
  logic        rom_sel;
  logic [18:0] rom_addr;
  logic        cart_ram_sel;
  logic [14:0] cart_ram_addr;
  logic        sys_ram_sel;
  logic [12:0] sys_ram_addr;

  int checks = 0;
  int errors = 0;

  paging_mapper #(.ROM_BANK_BITS(5), .SETTLE_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .paging_RQ(paging_RQ), .MREQ(MREQ), .Rd_Wr(Rd_Wr),
    .addr(addr), .data_in(data_in), .flush0(flush0), .busy(busy),
    .rom_sel(rom_sel), .rom_addr(rom_addr), .cart_ram_sel(cart_ram_sel),
    .cart_ram_addr(cart_ram_addr), .sys_ram_sel(sys_ram_sel), .sys_ram_addr(sys_ram_addr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a combinational lookup and check the ROM address and select.
  task automatic rom_look(input logic [15:0] a, input logic [18:0] exp);
    addr = a;
    #1;
    chk("rom_sel", {31'd0, rom_sel}, 32'd1);
    chk("rom_addr", {13'd0, rom_addr}, {13'd0, exp});
    $display("look addr=%04h rom_addr=%05h", a, rom_addr);
  endtask

  // Issue one request. The request is accepted at the first edge, which is cycle N.
  // va is viewed from N+1 on, so the old mapping is checked at N+1 and the new one at N+2.
  // Flush is expected only at N+4. The request is held for 'extra' cycles after flush.
  task automatic page_req(input logic [15:0] a, input logic [7:0] d, input logic wr,
                          input int extra, input logic [15:0] va,
                          input logic [18:0] old_exp, input logic [18:0] new_exp);
    @(posedge CLK); #1;
    paging_RQ = 1'b1; MREQ = 1'b1; Rd_Wr = !wr; addr = a; data_in = d;
    for (int k = 1; k <= 5 + extra; k++) begin
      @(posedge CLK); #1;
      if (k == 1) begin
        // The request is already captured, so scrambling the bus must have no effect.
        addr = va; data_in = ~d; Rd_Wr = 1'b0; MREQ = 1'b1;
        #1;
        chk("old_map", {13'd0, rom_addr}, {13'd0, old_exp});
      end
      if (k == 2) chk("new_map", {13'd0, rom_addr}, {13'd0, new_exp});
      chk("flush0", {31'd0, flush0}, {31'd0, (k == 4)});
      chk("busy", {31'd0, busy}, 32'd1);
    end
    paging_RQ = 1'b0; MREQ = 1'b0; Rd_Wr = 1'b1;
    @(posedge CLK); #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_flush", {31'd0, flush0}, 32'd0);
    chk("final_map", {13'd0, rom_addr}, {13'd0, new_exp});
    $display("req addr=%04h data=%02h wr=%0d extra=%0d view=%04h rom_addr=%05h", a, d, wr, extra, va, rom_addr);
  endtask

  initial begin
    // 1: reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flush", {31'd0, flush0}, 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;
    rom_look(16'h4000, 19'h04000);
    rom_look(16'h8000, 19'h08000);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("flush_idle", {31'd0, flush0}, 32'd0);
    addr = 16'hC123; #1;
    chk("sys_sel", {31'd0, sys_ram_sel}, 32'd1);
    chk("sys_rom_sel", {31'd0, rom_sel}, 32'd0);
    chk("sys_addr", {19'd0, sys_ram_addr}, 32'h0123);
    addr = 16'hFFFF; #1;
    chk("sys_addr_top", {19'd0, sys_ram_addr}, 32'h1FFF);
    chk("cart_sel_off", {31'd0, cart_ram_sel}, 32'd0);

    // 2: bank2 = 5
    page_req(16'hFFFF, 8'h05, 1'b1, 0, 16'h8123, 19'h08123, 19'h14123);
    // 3: bank0 = 3; the first 1KB stays fixed to bank 0
    page_req(16'hFFFD, 8'h03, 1'b1, 0, 16'h0400, 19'h00400, 19'h0C400);
    rom_look(16'h0200, 19'h00200);
    rom_look(16'h03FF, 19'h003FF);
    // 4: bank1 = 0x25, which wraps to 5
    page_req(16'hFFFE, 8'h25, 1'b1, 0, 16'h4010, 19'h04010, 19'h14010);
    // Spurious read request: the handshake completes without a write
    page_req(16'hFFFD, 8'h1F, 1'b0, 0, 16'h0400, 19'h0C400, 19'h0C400);
    // 6a: request held past flush; no second write and no second flush
    page_req(16'hFFFF, 8'h06, 1'b1, 3, 16'h8000, 19'h14000, 19'h18000);

    // 6b: reset asserted during SETTLE
    @(posedge CLK); #1;
    paging_RQ = 1'b1; MREQ = 1'b1; Rd_Wr = 1'b0; addr = 16'hFFFE; data_in = 8'h09;
    @(posedge CLK); #1;
    addr = 16'h4000;
    @(posedge CLK); #1;
    chk("pre_rst_map", {13'd0, rom_addr}, 32'h24000);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    RST = 1'b1;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_flush", {31'd0, flush0}, 32'd0);
    chk("async_bank1", {13'd0, rom_addr}, 32'h04000);
    paging_RQ = 1'b0; MREQ = 1'b0; Rd_Wr = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK); #1;
      chk("no_flush", {31'd0, flush0}, 32'd0);
    end
    rom_look(16'h0400, 19'h00400);
    rom_look(16'h4000, 19'h04000);
    rom_look(16'h8000, 19'h08000);
    $display("reset in SETTLE: banks restored");

    // 5: ctrl = 0x0C
`ifdef CART_RAM_EN
    page_req(16'hFFFC, 8'h0C, 1'b1, 0, 16'h4001, 19'h04001, 19'h04001);
    addr = 16'h8001; #1;
    chk("cart_sel", {31'd0, cart_ram_sel}, 32'd1);
    chk("cart_rom_sel", {31'd0, rom_sel}, 32'd0);
    chk("cart_addr", {17'd0, cart_ram_addr}, 32'h4001);
    $display("ctrl=0C addr=8001 cart_ram_sel=%0d cart_ram_addr=%04h", cart_ram_sel, cart_ram_addr);
`else
    page_req(16'hFFFC, 8'h0C, 1'b1, 0, 16'h8001, 19'h08001, 19'h08001);
    addr = 16'h8001; #1;
    chk("nocart_sel", {31'd0, cart_ram_sel}, 32'd0);
    chk("nocart_rom_sel", {31'd0, rom_sel}, 32'd1);
    chk("nocart_addr", {17'd0, cart_ram_addr}, 32'h0);
    $display("ctrl=0C addr=8001 rom_sel=%0d rom_addr=%05h", rom_sel, rom_addr);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
